// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader (length, payload, xor checksum) into instruction RAM
module prog_loader #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [5:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] csum_q, csum_d;
    logic [5:0] cnt_q, cnt_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       accept;

    assign byte_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign accept     = byte_valid && byte_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = 6'd0;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d  = byte_data;
                    csum_d = byte_data;
                    if (byte_data == 8'd0 || byte_data > DEPTH_B) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = {2'b00, cnt_q};
                    mem_data_d = byte_data;
                    csum_d     = csum_q ^ byte_data;
                    cnt_d      = cnt_q + 6'd1;
                    if (({2'b00, cnt_q} + 8'd1) == len_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (byte_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            csum_q     <= 8'd0;
            cnt_q      <= 6'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 8'd0;
            mem_data_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       err;
    logic [5:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int base;
    logic [7:0] ram [0:255];

    prog_loader #(.DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // RAM model: captures on the edge after the write pulse appears
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr] = mem_data;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_loaded, 0);
        rst_n = 1'b1;
        tick();

        // good load
        base = we_cnt;
        pulse_start();
        chk("good_ready", byte_ready, 1);
        chk("good_busy", busy, 1);
        send(8'h03); send(8'h11); send(8'h22);
        chk("good_we_pulse", mem_we, 1);
        send(8'h33); send(8'h03);
        chk("good_done", done, 1);
        chk("good_err", err, 0);
        chk("good_busy_fall", busy, 0);
        chk("good_words", words_loaded, 3);
        chk("good_we_cnt", we_cnt - base, 3);
        chk("good_ram0", ram[0], 8'h11);
        chk("good_ram1", ram[1], 8'h22);
        chk("good_ram2", ram[2], 8'h33);
        chk("good_we_idle", mem_we, 0);

        // bad checksum
        base = we_cnt;
        pulse_start();
        send(8'h03); send(8'h44); send(8'h55); send(8'h66); send(8'h55);
        chk("bad_err", err, 1);
        chk("bad_done", done, 0);
        chk("bad_words", words_loaded, 3);
        chk("bad_we_cnt", we_cnt - base, 3);
        chk("bad_ram2", ram[2], 8'h66);

        // illegal length 0, with a byte offered alongside start in ERR
        base = we_cnt;
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h01;
        tick();
        start = 1'b0; byte_valid = 1'b0;
        chk("sim_busy", busy, 1);
        chk("sim_err_clr", err, 0);
        send(8'h00);
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_we_cnt", we_cnt - base, 0);

        // illegal length 33
        base = we_cnt;
        pulse_start();
        send(8'h21);
        chk("len33_err", err, 1);
        chk("len33_busy", busy, 0);
        chk("len33_ready", byte_ready, 0);
        tick();
        chk("len33_we_cnt", we_cnt - base, 0);

        // max length with random backpressure
        base = we_cnt;
        pulse_start();
        send(8'h20);
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(8'(i));
        end
        repeat ($urandom_range(0, 2)) tick();
        send(8'h20);
        chk("max_done", done, 1);
        chk("max_err", err, 0);
        chk("max_words", words_loaded, 32);
        chk("max_we_cnt", we_cnt - base, 32);
        for (int i = 0; i < 32; i++) chk($sformatf("max_ram%0d", i), ram[i], i);

        // reset mid-DATA
        pulse_start();
        send(8'h03); send(8'h77); send(8'h88);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", byte_ready, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_data", mem_data, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_words", words_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        base = we_cnt;
        pulse_start();
        send(8'h01); send(8'hAA); send(8'hAB);
        chk("one_done", done, 1);
        chk("one_we_cnt", we_cnt - base, 1);
        chk("one_ram0", ram[0], 8'hAA);

        // start during DATA ignored, then restart clears status
        pulse_start();
        send(8'h02); send(8'h10);
        start = 1'b1;
        send(8'h20);
        start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_words", words_loaded, 2);
        send(8'h32);
        chk("ign_done", done, 1);
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_words", words_loaded, 0);
        chk("restart_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
